// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data widths, ALU op
// codes, the arbiter FSM state encoding and the registered operand bundle.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned ALU_OP_MAX = 9;

  // ALU op codes; anything above ALU_OP_MAX is illegal
  localparam logic [CTRL_W-1:0] ALU_NOP = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_NOR = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SLL = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_SRL = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_SRA = CTRL_W'(9);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Operands captured from the granted requester
  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

  function automatic logic op_is_legal(input logic [CTRL_W-1:0] ctrl);
    return 32'(ctrl) <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the ALU arbiter.
//   master : requesters + result consumer (drive req_*, resp_ready)
//   slave  : the arbiter (drives req_ready, resp_*)
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [CTRL_W-1:0]  req0_ctrl;
  logic [CTRL_W-1:0]  req1_ctrl;
  logic [DATA_W-1:0]  req0_a;
  logic [DATA_W-1:0]  req0_b;
  logic [DATA_W-1:0]  req1_a;
  logic [DATA_W-1:0]  req1_b;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [SHAMT_W-1:0] req1_shamt;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [DATA_W-1:0]  resp_out;
  logic               resp_zero;
  logic               resp_err;

  modport master (
    output req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
           req0_shamt, req1_shamt, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req0_ctrl, req1_ctrl, req0_a, req0_b, req1_a, req1_b,
           req0_shamt, req1_shamt, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out, resp_zero, resp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the arbiter.
//   ctrl     : op code (illegal codes produce 0)
//   a, b     : operands; shifts operate on b
//   shamt    : shift amount
//   result_c : combinational result
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result_c
);

  always_comb begin
    result_c = '0;
    case (ctrl)
      ALU_NOP: result_c = '0;
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_NOR: result_c = ~(a | b);
      ALU_SLT: result_c = DATA_W'($signed(a) < $signed(b));
      ALU_SLL: result_c = b << shamt;
      ALU_SRL: result_c = b >> shamt;
      ALU_SRA: result_c = $unsigned($signed(b) >>> shamt);
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters. One request is granted
// per transaction (round-robin or fixed priority), its operands registered,
// evaluated in EXEC and returned in RESP tagged with the requester id.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : alu_arbiter_if.slave (req_valid/req_ready, req0/1 payloads,
//         resp_valid/resp_ready, resp_id/out/zero/err)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  alu_req_t          op_q, op_d;
  logic              op_id_q, op_id_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] resp_out_q, resp_out_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_err_q, resp_err_d;

  logic              sel_id_c;
  logic [1:0]        req_ready_c;
  logic              xfer_c;
  alu_req_t          sel_req_c;
  logic [DATA_W-1:0] alu_result_c;

  // Winner among the currently valid requesters
  always_comb begin
    sel_id_c = 1'b0;
    case (bus.req_valid)
      2'b01:   sel_id_c = 1'b0;
      2'b10:   sel_id_c = 1'b1;
      2'b11:   sel_id_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      default: sel_id_c = 1'b0;
    endcase
  end

  // Only the winner sees ready, and only while idle and out of reset
  always_comb begin
    req_ready_c = '0;
    if (!rst && (state_q == ST_IDLE) && bus.req_valid[sel_id_c]) begin
      req_ready_c[sel_id_c] = 1'b1;
    end
  end

  assign xfer_c = |(bus.req_valid & req_ready_c);

  // Payload of the selected requester
  always_comb begin
    if (sel_id_c) begin
      sel_req_c = '{ctrl: bus.req1_ctrl, a: bus.req1_a, b: bus.req1_b,
                    shamt: bus.req1_shamt};
    end else begin
      sel_req_c = '{ctrl: bus.req0_ctrl, a: bus.req0_a, b: bus.req0_b,
                    shamt: bus.req0_shamt};
    end
  end

  alu_arbiter_alu u_alu (
    .ctrl     (op_q.ctrl),
    .a        (op_q.a),
    .b        (op_q.b),
    .shamt    (op_q.shamt),
    .result_c (alu_result_c)
  );

  // Next-state and result capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_out_d   = resp_out_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          op_d         = sel_req_c;
          op_id_d      = sel_id_c;
          last_grant_d = sel_id_c;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Illegal ops are forced to a zero result regardless of the ALU
        resp_out_d   = op_is_legal(op_q.ctrl) ? alu_result_c : '0;
        resp_zero_d  = !op_is_legal(op_q.ctrl) || (alu_result_c == '0);
        resp_err_d   = !op_is_legal(op_q.ctrl);
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_out_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_zero  = resp_zero_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share
// one stimulus stream; each is compared every cycle against its own
// transaction-level reference model, plus directed scenario checks.
module tb_alu_arbiter;

  logic clk;
  logic s_rst;
  logic [1:0] s_valid;
  logic [3:0] s_ctrl0, s_ctrl1;
  logic [31:0] s_a0, s_b0, s_a1, s_b1;
  logic [4:0] s_sh0, s_sh1;
  logic s_rready;

  int n_total = 0;
  int n_bad = 0;

  alu_arbiter_if bus_rr ();
  alu_arbiter_if bus_fp ();

  assign bus_rr.req_valid = s_valid;  assign bus_fp.req_valid = s_valid;
  assign bus_rr.req0_ctrl = s_ctrl0;  assign bus_fp.req0_ctrl = s_ctrl0;
  assign bus_rr.req1_ctrl = s_ctrl1;  assign bus_fp.req1_ctrl = s_ctrl1;
  assign bus_rr.req0_a = s_a0;        assign bus_fp.req0_a = s_a0;
  assign bus_rr.req0_b = s_b0;        assign bus_fp.req0_b = s_b0;
  assign bus_rr.req1_a = s_a1;        assign bus_fp.req1_a = s_a1;
  assign bus_rr.req1_b = s_b1;        assign bus_fp.req1_b = s_b1;
  assign bus_rr.req0_shamt = s_sh0;   assign bus_fp.req0_shamt = s_sh0;
  assign bus_rr.req1_shamt = s_sh1;   assign bus_fp.req1_shamt = s_sh1;
  assign bus_rr.resp_ready = s_rready; assign bus_fp.resp_ready = s_rready;

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst(s_rst), .bus(bus_rr));
  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst(s_rst), .bus(bus_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // Reference model, index 0 = round-robin instance, 1 = fixed priority.
  // phase: 0 waiting for a request, 1 operation in flight, 2 result offered.
  int          m_phase[2];
  bit          m_last[2];
  bit          m_rv[2], m_id[2], m_zero[2], m_err[2];
  logic [31:0] m_out[2];
  bit          m_pid[2], m_perr[2];
  logic [31:0] m_pout[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
    logic [31:0] fill;
    fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return ~(a | b);
      6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7: return b << sh;
      8: return b >> sh;
      9: return (b >> sh) | fill;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit winner(input int k);
    if (s_valid == 2'b01) return 1'b0;
    if (s_valid == 2'b10) return 1'b1;
    if (k == 1) return 1'b0;
    return !m_last[k];
  endfunction

  function automatic logic [1:0] exp_ready(input int k);
    if (s_rst || m_phase[k] != 0 || s_valid == 2'b00) return 2'b00;
    return winner(k) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_last[k] = 1'b1; m_rv[k] = 1'b0; m_id[k] = 1'b0;
    m_out[k] = 32'd0; m_zero[k] = 1'b0; m_err[k] = 1'b0;
  endtask

  task automatic model_update(input int k);
    bit w;
    int op;
    if (s_rst) begin
      model_reset(k);
    end else if (m_phase[k] == 0) begin
      if (s_valid != 2'b00) begin
        w = winner(k);
        m_last[k] = w;
        m_pid[k] = w;
        op = w ? int'(s_ctrl1) : int'(s_ctrl0);
        m_pout[k] = w ? ref_alu(op, s_a1, s_b1, int'(s_sh1)) : ref_alu(op, s_a0, s_b0, int'(s_sh0));
        m_perr[k] = (op >= 10);
        m_phase[k] = 1;
      end
    end else if (m_phase[k] == 1) begin
      m_out[k] = m_pout[k]; m_id[k] = m_pid[k]; m_err[k] = m_perr[k];
      m_zero[k] = (m_pout[k] == 32'd0); m_rv[k] = 1'b1; m_phase[k] = 2;
    end else if (s_rready) begin
      m_rv[k] = 1'b0; m_phase[k] = 0;
    end
  endtask

  task automatic check_dut(input int k, input logic [1:0] rdy, input logic rv, input logic id,
                           input logic [31:0] out, input logic z, input logic e);
    string t;
    t = (k == 0) ? "rr" : "fp";
    check_eq({t, "_req_ready"}, 32'(rdy), 32'(exp_ready(k)));
    check_eq({t, "_resp_valid"}, 32'(rv), 32'(m_rv[k]));
    check_eq({t, "_resp_id"}, 32'(id), 32'(m_id[k]));
    check_eq({t, "_resp_out"}, out, m_out[k]);
    check_eq({t, "_resp_zero"}, 32'(z), 32'(m_zero[k]));
    check_eq({t, "_resp_err"}, 32'(e), 32'(m_err[k]));
  endtask

  // One clock: compare at negedge, advance the model at posedge, return #1 later
  task automatic step();
    @(negedge clk);
    check_dut(0, bus_rr.req_ready, bus_rr.resp_valid, bus_rr.resp_id, bus_rr.resp_out,
              bus_rr.resp_zero, bus_rr.resp_err);
    check_dut(1, bus_fp.req_ready, bus_fp.resp_valid, bus_fp.resp_id, bus_fp.resp_out,
              bus_fp.resp_zero, bus_fp.resp_err);
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic set_req(input int r, input int ctrl, input logic [31:0] a,
                         input logic [31:0] b, input int sh);
    if (r == 0) begin
      s_ctrl0 = 4'(ctrl); s_a0 = a; s_b0 = b; s_sh0 = 5'(sh);
    end else begin
      s_ctrl1 = 4'(ctrl); s_a1 = a; s_b1 = b; s_sh1 = 5'(sh);
    end
  endtask

  task automatic do_reset(input int cycles);
    s_rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    s_rst = 1'b0;
  endtask

  logic ids_rr[$];
  logic ids_fp[$];

  initial begin
    s_rst = 1'b1; s_valid = 2'b11; s_rready = 1'b1;
    set_req(0, 0, 32'd0, 32'd0, 0);
    set_req(1, 0, 32'd0, 32'd0, 0);
    model_reset(0); model_reset(1);

    // Reset with both requests pending: nothing granted, outputs at reset values
    do_reset(2);
    check_eq("rst_req_ready", 32'(bus_rr.req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(bus_rr.resp_valid), 32'd0);
    check_eq("rst_resp_out", bus_rr.resp_out, 32'd0);

    // Single requester 0: 5 + 7
    s_valid = 2'b01;
    set_req(0, 1, 32'd5, 32'd7, 0);
    step();
    s_valid = 2'b00;
    step();
    check_eq("t1_resp_valid", 32'(bus_rr.resp_valid), 32'd1);
    check_eq("t1_resp_id", 32'(bus_rr.resp_id), 32'd0);
    check_eq("t1_resp_out", bus_rr.resp_out, 32'd12);
    check_eq("t1_resp_zero", 32'(bus_rr.resp_zero), 32'd0);
    check_eq("t1_resp_err", 32'(bus_rr.resp_err), 32'd0);
    step();

    // Both valid continuously after a fresh reset
    do_reset(1);
    s_valid = 2'b11;
    set_req(0, 1, 32'd3, 32'd4, 0);
    set_req(1, 6, 32'hFFFF_FFFF, 32'd1, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_rr.resp_valid) begin
        ids_rr.push_back(bus_rr.resp_id);
        check_eq("t2_rr_out", bus_rr.resp_out, bus_rr.resp_id ? 32'd1 : 32'd7);
      end
      if (bus_fp.resp_valid) ids_fp.push_back(bus_fp.resp_id);
    end
    check_eq("t2_rr_count", 32'(ids_rr.size()), 32'd4);
    check_eq("t2_fp_count", 32'(ids_fp.size()), 32'd4);
    for (int i = 0; i < ids_rr.size(); i++) check_eq("t2_rr_order", 32'(ids_rr[i]), 32'(i % 2));
    for (int i = 0; i < ids_fp.size(); i++) check_eq("t2_fp_only0", 32'(ids_fp[i]), 32'd0);
    s_valid = 2'b10;
    step();
    step();
    check_eq("t2_fp_drop_valid", 32'(bus_fp.resp_valid), 32'd1);
    check_eq("t2_fp_drop_id", 32'(bus_fp.resp_id), 32'd1);
    s_valid = 2'b00;
    step();

    // Illegal op, then a zero result from a legal op
    s_valid = 2'b10;
    set_req(1, 12, 32'h1234_5678, 32'h0000_00FF, 3);
    step();
    s_valid = 2'b00;
    step();
    check_eq("t4_ill_err", 32'(bus_rr.resp_err), 32'd1);
    check_eq("t4_ill_out", bus_rr.resp_out, 32'd0);
    check_eq("t4_ill_zero", 32'(bus_rr.resp_zero), 32'd1);
    step();
    s_valid = 2'b01;
    set_req(0, 2, 32'd9, 32'd9, 0);
    step();
    s_valid = 2'b00;
    step();
    check_eq("t4_sub_zero", 32'(bus_rr.resp_zero), 32'd1);
    check_eq("t4_sub_err", 32'(bus_rr.resp_err), 32'd0);
    step();

    // Back-pressure: result held, no grants while both requests wait
    s_valid = 2'b01;
    s_rready = 1'b0;
    set_req(0, 1, 32'd100, 32'd23, 0);
    step();
    s_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_bp_valid", 32'(bus_rr.resp_valid), 32'd1);
      check_eq("t3_bp_out", bus_rr.resp_out, 32'd123);
      check_eq("t3_bp_id", 32'(bus_rr.resp_id), 32'd0);
      check_eq("t3_bp_ready", 32'(bus_rr.req_ready), 32'd0);
    end
    s_valid = 2'b00;
    s_rready = 1'b1;
    step();

    // Reset while an op is in EXEC: it is dropped
    s_valid = 2'b01;
    set_req(0, 1, 32'd40, 32'd2, 0);
    step();
    s_valid = 2'b00;
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_no_resp", 32'(bus_rr.resp_valid), 32'd0);
    end
    check_eq("t5_out_reset", bus_rr.resp_out, 32'd0);
    s_valid = 2'b11;
    set_req(0, 4, 32'hF0, 32'h0F, 0);
    set_req(1, 3, 32'hF0, 32'h0F, 0);
    step();
    s_valid = 2'b00;
    step();
    check_eq("t5_tie_id", 32'(bus_rr.resp_id), 32'd0);
    check_eq("t5_tie_out", bus_rr.resp_out, 32'hFF);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 2'($urandom_range(0, 3));
        set_req(0, int'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 31)));
        set_req(1, int'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 31)));
        if ($urandom_range(0, 3) == 0) s_b0 = s_a0;
        if ($urandom_range(0, 3) == 0) s_b1 = s_a1;
      end
      s_rready = ($urandom_range(0, 9) < 7);
      s_rst = ($urandom_range(0, 63) == 0);
      step();
    end
    s_rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
